// File: rtl/game_pkg.sv
// Shared game definitions used by the laser hit judge, the movers and the
// color mapper.
//   hit_state_e : cowboy life-cycle state (ALIVE, INVULN, DEAD)
//   GAME_*      : screen and sprite geometry constants
package game_pkg;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } hit_state_e;

  localparam int GAME_POS_W        = 10;
  localparam int GAME_LASER_W      = 4;
  localparam int GAME_LASER_H      = 8;
  localparam int GAME_COWBOY_W     = 32;
  localparam int GAME_COWBOY_H     = 48;
  localparam int GAME_LASER_PARK_Y = 462;
  localparam int GAME_PARK_POS_Y   = 500;

endpackage

// File: rtl/bbox_overlap.sv
// Combinational axis-aligned bounding-box overlap test between box A and box B.
// Right/bottom edges are computed one bit wider than the coordinates so boxes
// near the screen edge never wrap. Touching edges do not count as overlap.
//   ax, ay  : box A top-left corner
//   bx, by  : box B top-left corner
//   overlap : 1 when the two boxes share at least one pixel
module bbox_overlap #(
  parameter int POS_W = 10,
  parameter int A_W   = 4,
  parameter int A_H   = 8,
  parameter int B_W   = 32,
  parameter int B_H   = 48
) (
  input  logic [POS_W-1:0] ax,
  input  logic [POS_W-1:0] ay,
  input  logic [POS_W-1:0] bx,
  input  logic [POS_W-1:0] by,
  output logic             overlap
);

  localparam logic [POS_W:0] A_W_E = (POS_W+1)'(A_W);
  localparam logic [POS_W:0] A_H_E = (POS_W+1)'(A_H);
  localparam logic [POS_W:0] B_W_E = (POS_W+1)'(B_W);
  localparam logic [POS_W:0] B_H_E = (POS_W+1)'(B_H);

  logic [POS_W:0] ax_e, ay_e, bx_e, by_e;

  assign ax_e = {1'b0, ax};
  assign ay_e = {1'b0, ay};
  assign bx_e = {1'b0, bx};
  assign by_e = {1'b0, by};

  assign overlap = (ax_e < bx_e + B_W_E) && (ax_e + A_W_E > bx_e) &&
                   (ay_e < by_e + B_H_E) && (ay_e + A_H_E > by_e);

endmodule

// File: rtl/laser_hit_judge.sv
// Laser hit judge: on every frame tick compares the alien laser against the
// cowboy hitbox, counts down lives, runs the post-hit invulnerability window
// and raises the game-over level.
//   Clk, Reset     : system clock, synchronous active-high reset
//   frame_clk      : ~60 Hz frame strobe, rising edge detected internally
//   LaserX/LaserY  : laser top-left position
//   CowboyX/CowboyY: cowboy top-left position
//   Restart        : new-game request, honoured only after game over
//   GG             : game over, held high until restart
//   Hit            : one-Clk pulse per registered hit
//   Lives          : remaining lives
//   Blink          : hide-cowboy flag while invulnerable
module laser_hit_judge
  import game_pkg::*;
#(
  parameter int LASER_W       = GAME_LASER_W,
  parameter int LASER_H       = GAME_LASER_H,
  parameter int COWBOY_W      = GAME_COWBOY_W,
  parameter int COWBOY_H      = GAME_COWBOY_H,
  parameter int LASER_PARK_Y  = GAME_LASER_PARK_Y,
  parameter int LIVES_INIT    = 3,
  parameter int INVULN_FRAMES = 60
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [9:0] LaserX,
  input  logic [9:0] LaserY,
  input  logic [9:0] CowboyX,
  input  logic [9:0] CowboyY,
  input  logic       Restart,
  output logic       GG,
  output logic       Hit,
  output logic [2:0] Lives,
  output logic       Blink
);

  // Counter is at least 3 bits wide because Blink is taken from bit 2.
  localparam int CNT_W = ($clog2(INVULN_FRAMES + 1) < 3) ? 3 : $clog2(INVULN_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(INVULN_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       LIVES_LD = 3'(LIVES_INIT);
  localparam logic [10:0]      PARK_E   = 11'(LASER_PARK_Y);

  logic             frame_clk_d, frame_tick;
  logic             box_ovl, ovl;
  hit_state_e       state, state_nxt;
  logic [2:0]       lives_q, lives_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             gg_q, gg_nxt;
  logic             hit_q, hit_nxt;

  bbox_overlap #(
    .POS_W (10),
    .A_W   (LASER_W),
    .A_H   (LASER_H),
    .B_W   (COWBOY_W),
    .B_H   (COWBOY_H)
  ) u_laser_vs_cowboy (
    .ax      (LaserX),
    .ay      (LaserY),
    .bx      (CowboyX),
    .by      (CowboyY),
    .overlap (box_ovl)
  );

  // A parked laser sits far below the playfield and must never score.
  assign ovl = box_ovl && ({1'b0, LaserY} < PARK_E);

  // Stage p0: frame edge detect and state registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      // Tracking frame_clk during reset keeps a strobe that is already high
      // from looking like a fresh rising edge once reset releases.
      frame_clk_d <= frame_clk;
      frame_tick  <= 1'b0;
      state       <= ALIVE;
      lives_q     <= LIVES_LD;
      cnt_q       <= '0;
      gg_q        <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      frame_clk_d <= frame_clk;
      frame_tick  <= frame_clk & ~frame_clk_d;
      state       <= state_nxt;
      lives_q     <= lives_nxt;
      cnt_q       <= cnt_nxt;
      gg_q        <= gg_nxt;
      hit_q       <= hit_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lives_nxt = lives_q;
    cnt_nxt   = cnt_q;
    gg_nxt    = gg_q;
    hit_nxt   = 1'b0;
    case (state)
      ALIVE: begin
        if (frame_tick && ovl) begin
          hit_nxt   = 1'b1;
          lives_nxt = lives_q - 3'd1;
          if (lives_q == 3'd1) begin
            state_nxt = DEAD;
            gg_nxt    = 1'b1;
          end else begin
            state_nxt = INVULN;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      INVULN: begin
        if (frame_tick) begin
          cnt_nxt = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_nxt = ALIVE;
        end
      end
      DEAD: begin
        // Restart outranks a coincident frame tick; no hit is evaluated.
        if (Restart) begin
          state_nxt = ALIVE;
          lives_nxt = LIVES_LD;
          gg_nxt    = 1'b0;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = ALIVE;
    endcase
  end

  assign GG    = gg_q;
  assign Hit   = hit_q;
  assign Lives = lives_q;
  assign Blink = (state == INVULN) && cnt_q[2];

endmodule

// File: tb/tb_laser_hit_judge.sv
module tb_laser_hit_judge;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [9:0] LaserX = '0, LaserY = '0, CowboyX = '0, CowboyY = '0;
  logic       Restart = 1'b0;
  logic       GG, Hit, Blink;
  logic [2:0] Lives;

  int errors = 0;
  int checks = 0;

  laser_hit_judge dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .LaserX    (LaserX),
    .LaserY    (LaserY),
    .CowboyX   (CowboyX),
    .CowboyY   (CowboyY),
    .Restart   (Restart),
    .GG        (GG),
    .Hit       (Hit),
    .Lives     (Lives),
    .Blink     (Blink)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic [9:0] lx, ly, cx, cy;
    int         exp_hits;
    int         exp_lives;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; frame_clk = 1'b0; Restart = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  // One frame strobe; counts the Clk cycles in which Hit is high.
  task automatic frame(output int hits);
    hits = 0;
    @(negedge Clk) frame_clk = 1'b1;
    repeat (4) begin @(posedge Clk); #1; if (Hit === 1'b1) hits++; end
    @(negedge Clk) frame_clk = 1'b0;
    repeat (2) begin @(posedge Clk); #1; if (Hit === 1'b1) hits++; end
  endtask

  task automatic frames(input int n, output int hits);
    int h;
    hits = 0;
    for (int i = 0; i < n; i++) begin
      frame(h);
      hits += h;
    end
  endtask

  task automatic place(input int lx, input int ly, input int cx, input int cy);
    LaserX = 10'(lx); LaserY = 10'(ly); CowboyX = 10'(cx); CowboyY = 10'(cy);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h;

    vecs[0]  = '{"overlap_basic",   10'd310, 10'd395, 10'd300, 10'd400, 1, 2};
    vecs[1]  = '{"parked",          10'd300, 10'd500, 10'd300, 10'd400, 0, 3};
    vecs[2]  = '{"right_edge",      10'd332, 10'd400, 10'd300, 10'd400, 0, 3};
    vecs[3]  = '{"right_inside",    10'd328, 10'd400, 10'd300, 10'd400, 1, 2};
    vecs[4]  = '{"left_edge",       10'd296, 10'd400, 10'd300, 10'd400, 0, 3};
    vecs[5]  = '{"left_inside",     10'd297, 10'd400, 10'd300, 10'd400, 1, 2};
    vecs[6]  = '{"top_edge",        10'd300, 10'd392, 10'd300, 10'd400, 0, 3};
    vecs[7]  = '{"top_inside",      10'd300, 10'd393, 10'd300, 10'd400, 1, 2};
    vecs[8]  = '{"bottom_inside",   10'd300, 10'd447, 10'd300, 10'd400, 1, 2};
    vecs[9]  = '{"bottom_edge",     10'd300, 10'd448, 10'd300, 10'd400, 0, 3};
    vecs[10] = '{"park_minus_1",    10'd300, 10'd461, 10'd300, 10'd430, 1, 2};
    vecs[11] = '{"park_exact",      10'd300, 10'd462, 10'd300, 10'd430, 0, 3};
    vecs[12] = '{"origin",          10'd0,   10'd0,   10'd0,   10'd0,   1, 2};
    vecs[13] = '{"no_wrap_right",   10'd1020,10'd410, 10'd1000,10'd400, 1, 2};
    vecs[14] = '{"no_wrap_maxx",    10'd1023,10'd400, 10'd1000,10'd400, 1, 2};

    // Reset state
    do_reset();
    #1;
    check("rst_gg", GG, 0);
    check("rst_hit", Hit, 0);
    check("rst_lives", Lives, 3);
    check("rst_blink", Blink, 0);

    // Table: single frame per vector from a fresh reset
    foreach (vecs[i]) begin
      do_reset();
      place(vecs[i].lx, vecs[i].ly, vecs[i].cx, vecs[i].cy);
      frame(h);
      check({vecs[i].name, "_hits"}, h, vecs[i].exp_hits);
      check({vecs[i].name, "_lives"}, Lives, vecs[i].exp_lives);
    end

    // Parked laser over cowboy X for 10 frames
    do_reset();
    place(300, 500, 300, 400);
    frames(10, h);
    check("parked10_hits", h, 0);
    check("parked10_lives", Lives, 3);

    // First hit with exact latency
    do_reset();
    place(310, 395, 300, 400);
    @(negedge Clk) frame_clk = 1'b1;
    @(posedge Clk); #1;
    check("lat_hit_early", Hit, 0);
    check("lat_lives_early", Lives, 3);
    @(posedge Clk); #1;
    check("lat_hit", Hit, 1);
    check("lat_lives", Lives, 2);
    check("lat_blink", Blink, 1);
    check("lat_gg", GG, 0);
    @(posedge Clk); #1;
    check("lat_hit_width", Hit, 0);
    @(negedge Clk) frame_clk = 1'b0;
    repeat (2) @(posedge Clk);

    // Restart is ignored while invulnerable
    @(negedge Clk) Restart = 1'b1;
    @(negedge Clk) Restart = 1'b0;
    #1;
    check("inv_restart_lives", Lives, 2);
    check("inv_restart_blink", Blink, 1);

    // Invulnerability window with continuous overlap
    frames(4, h);
    check("inv4_hits", h, 0);
    check("inv4_blink", Blink, 0);
    frames(55, h);
    check("inv59_hits", h, 0);
    frames(1, h);
    check("inv60_hits", h, 0);
    check("inv60_blink", Blink, 0);
    check("inv60_lives", Lives, 2);
    frame(h);
    check("second_hit", h, 1);
    check("second_lives", Lives, 1);

    // Third hit ends the game
    frames(60, h);
    check("inv_b_hits", h, 0);
    frame(h);
    check("third_hit", h, 1);
    check("dead_lives", Lives, 0);
    check("dead_gg", GG, 1);
    check("dead_blink", Blink, 0);
    frames(3, h);
    check("dead_more_hits", h, 0);
    check("dead_lives_hold", Lives, 0);
    check("dead_gg_hold", GG, 1);

    // Restart coinciding with a frame tick in DEAD
    @(negedge Clk) frame_clk = 1'b1;
    @(posedge Clk);
    @(negedge Clk) Restart = 1'b1;
    @(posedge Clk); #1;
    check("restart_gg", GG, 0);
    check("restart_lives", Lives, 3);
    check("restart_hit", Hit, 0);
    @(negedge Clk) begin Restart = 1'b0; frame_clk = 1'b0; end
    h = 0;
    repeat (3) begin @(posedge Clk); #1; if (Hit === 1'b1) h++; end
    check("restart_no_hit", h, 0);
    frame(h);
    check("newgame_hit", h, 1);
    check("newgame_lives", Lives, 2);

    // Reset in the middle of invulnerability, strobe held high across it
    do_reset();
    place(310, 395, 300, 400);
    frame(h);
    check("r6_hit", h, 1);
    frames(30, h);
    check("r6_inv_hits", h, 0);
    check("r6_blink_pre", Blink, 1);
    @(negedge Clk) begin frame_clk = 1'b1; Reset = 1'b1; end
    repeat (2) @(posedge Clk);
    #1;
    check("r6_lives", Lives, 3);
    check("r6_blink", Blink, 0);
    check("r6_gg", GG, 0);
    @(negedge Clk) Reset = 1'b0;
    h = 0;
    repeat (4) begin @(posedge Clk); #1; if (Hit === 1'b1) h++; end
    check("r6_held_strobe", h, 0);
    check("r6_held_lives", Lives, 3);
    @(negedge Clk) frame_clk = 1'b0;
    repeat (2) @(posedge Clk);
    frame(h);
    check("r6_alive_hit", h, 1);
    check("r6_alive_lives", Lives, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
